// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction loader, its packer and the bench:
// opcodes, field bit positions and the loader state encoding.
package isa_pkg;

    localparam logic [2:0] OP_RTYPE  = 3'b000;
    localparam logic [2:0] OP_ALUI   = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;

    // LSB position of each field inside the 16-bit instruction word
    localparam int POS_OP    = 13;
    localparam int POS_RD    = 10;
    localparam int POS_RA    = 7;
    localparam int POS_RB    = 3;
    localparam int POS_FUNCT = 0;
    localparam int POS_IMM   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream into the loader plus the instruction-memory write bus out of it.
// master = bundle producer / memory side, slave = the loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [2:0]        in_rd;
    logic [2:0]        in_ra;
    logic [2:0]        in_rb;
    logic [1:0]        in_funct;
    logic [7:0]        in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb, in_funct, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb, in_funct, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational field-to-word packer: exact inverse of the decoder's field slicing,
// plus a flag for immediates that do not fit the 7-bit signed field.
module instr_pack
    import isa_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  ra,
    input  logic [2:0]  rb,
    input  logic [1:0]  funct,
    input  logic [7:0]  imm,
    output logic [15:0] word,
    output logic        range_err
);
    always_comb begin
        word = '0;
        word[POS_OP +: 3] = op;
        word[POS_RD +: 3] = rd;
        word[POS_RA +: 3] = ra;
        if (op == OP_RTYPE) begin
            word[POS_RB +: 3]    = rb;
            word[POS_FUNCT +: 2] = funct;
        end else begin
            word[POS_IMM +: 7] = imm[6:0];
        end
        // -64..63 fits only when the dropped sign bit matches bit 6
        range_err = (op != OP_RTYPE) && (imm[7] != imm[6]);
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them sequentially
// into instruction memory. Optional LOADER_CHECKSUM_EN adds a rotate-xor checksum output.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 finish,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]      count,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]          checksum,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_LOAD = 2'(LOAD);
    localparam logic [1:0] ST_DONE = 2'(DONE);
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    logic [1:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       word;
    logic              range_err;
    logic              ready;
    logic              accept;

    instr_pack u_pack (
        .op        (bus.in_op),
        .rd        (bus.in_rd),
        .ra        (bus.in_ra),
        .rb        (bus.in_rb),
        .funct     (bus.in_funct),
        .imm       (bus.in_imm),
        .word      (word),
        .range_err (range_err)
    );

    assign ready  = (state == ST_LOAD) && (count < MAX_CNT);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else if (start) begin
            // restart wins over finish and drops any bundle offered this cycle
            state  <= ST_LOAD;
            we_q   <= 1'b0;
            addr_q <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q  <= count[ADDR_W-1:0];
                wdata_q <= word;
                count   <= count + 1'b1;
                if (range_err) err <= 1'b1;
            end
            case (state)
                ST_LOAD: if (finish || (accept && (count + 1'b1 == MAX_CNT))) state <= ST_DONE;
                ST_IDLE, ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            checksum <= '0;
        else if (start)
            checksum <= '0;
        else if (we_q)
            checksum <= {checksum[14:0], checksum[15]} ^ wdata_q;
    end
`endif

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state == ST_LOAD);
    assign done           = (state == ST_DONE);
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (ADDR_W=8, MAX_WORDS=4).
// Checksum scenario is compiled only when LOADER_CHECKSUM_EN is defined.
module tb_instr_encoder_loader;
    logic       clk = 1'b0;
    logic       reset_n, start, finish;
    logic [8:0] count;
    logic       busy, done, err;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int w0;

    instr_encoder_loader_if #(.ADDR_W(8)) bus ();

    instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .finish   (finish),
        .bus      (bus),
        .count    (count),
`ifdef LOADER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.imem_we === 1'b1) wr_cnt++;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [2:0] op, rd, ra, rb, input logic [1:0] funct,
                         input logic [7:0] imm);
        bus.in_op = op; bus.in_rd = rd; bus.in_ra = ra; bus.in_rb = rb;
        bus.in_funct = funct; bus.in_imm = imm; bus.in_valid = 1'b1;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; finish = 1'b0;
        bus.in_valid = 1'b0; drive(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0); bus.in_valid = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.in_ready, bus.imem_we, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=00000", {bus.in_ready, bus.imem_we, busy, done, err});
        end
        checks++;
        if ({bus.imem_addr, bus.imem_wdata, count} !== 33'd0) begin
            errors++; $display("FAIL reset_regs addr=%h wdata=%h count=%0d want 0", bus.imem_addr, bus.imem_wdata, count);
        end
        @(negedge clk); reset_n = 1'b1;
        tick();
        finish = 1'b1; tick(); finish = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL finish_in_idle busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_rtype;
        pulse_start();
        checks++;
        if ({busy, bus.in_ready, count} !== {2'b11, 9'd0}) begin
            errors++; $display("FAIL start_load busy=%b ready=%b count=%0d want 1 1 0", busy, bus.in_ready, count);
        end
        // {000,001,010,0,011,0,10} = 0x051A; in_imm must be ignored
        drive(3'b000, 3'd1, 3'd2, 3'd3, 2'b10, 8'h5A);
        tick(); bus.in_valid = 1'b0;
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, count} !== {1'b1, 8'd0, 16'h051A, 9'd1}) begin
            errors++; $display("FAIL rtype_write we=%b addr=%0d wdata=%h count=%0d want 1 0 051a 1", bus.imem_we, bus.imem_addr, bus.imem_wdata, count);
        end
        tick();
        checks++;
        if (bus.imem_we !== 1'b0) begin
            errors++; $display("FAIL rtype_single_we got=%b want 0", bus.imem_we);
        end
    endtask

    task automatic test_imm_err;
        drive(3'b010, 3'd4, 3'd5, 3'd7, 2'b11, 8'hFF);
        tick();
        checks++;
        if ({bus.imem_wdata, bus.imem_addr, err} !== {16'h52FF, 8'd1, 1'b0}) begin
            errors++; $display("FAIL imm_neg1 wdata=%h addr=%0d err=%b want 52ff 1 0", bus.imem_wdata, bus.imem_addr, err);
        end
        drive(3'b001, 3'd0, 3'd0, 3'd0, 2'd0, 8'd64);
        tick(); bus.in_valid = 1'b0;
        checks++;
        if ({bus.imem_we, bus.imem_wdata, err, count} !== {1'b1, 16'h2040, 1'b1, 9'd3}) begin
            errors++; $display("FAIL imm_range we=%b wdata=%h err=%b count=%0d want 1 2040 1 3", bus.imem_we, bus.imem_wdata, err, count);
        end
        tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got=%b want 1", err);
        end
        pulse_start();
        checks++;
        if ({err, count, bus.imem_addr} !== {1'b0, 9'd0, 8'd0}) begin
            errors++; $display("FAIL start_clears err=%b count=%0d addr=%0d want 0 0 0", err, count, bus.imem_addr);
        end
    endtask

    task automatic test_max_words;
        pulse_start();
        w0 = wr_cnt;
        // {011,111,111,0000001} = 0x7F81
        drive(3'b011, 3'd7, 3'd7, 3'd0, 2'd0, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (k <= 4) begin
                if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, count} !== {1'b1, 8'(k-1), 16'h7F81, 9'(k)}) begin
                    errors++; $display("FAIL max_write%0d we=%b addr=%0d wdata=%h count=%0d want 1 %0d 7f81 %0d", k, bus.imem_we, bus.imem_addr, bus.imem_wdata, count, k-1, k);
                end
            end else if ({bus.imem_we, count} !== {1'b0, 9'd4}) begin
                errors++; $display("FAIL max_hold%0d we=%b count=%0d want 0 4", k, bus.imem_we, count);
            end
            if (k == 4) begin
                checks++;
                if ({bus.in_ready, done, busy} !== 3'b010) begin
                    errors++; $display("FAIL max_done ready/done/busy=%b want 010", {bus.in_ready, done, busy});
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_cnt - w0 != 4) begin
            errors++; $display("FAIL max_count writes=%0d want 4", wr_cnt - w0);
        end
    endtask

    task automatic test_finish;
        pulse_start();
        w0 = wr_cnt;
        // {100,011,110,1110000} = 0x8F70
        drive(3'b100, 3'd3, 3'd6, 3'd0, 2'd0, 8'hF0);
        tick(); tick();
        finish = 1'b1;
        tick(); finish = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, count, done, bus.in_ready} !== {1'b1, 8'd2, 16'h8F70, 9'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL finish_last we=%b addr=%0d wdata=%h count=%0d done=%b ready=%b want 1 2 8f70 3 1 0", bus.imem_we, bus.imem_addr, bus.imem_wdata, count, done, bus.in_ready);
        end
        tick();
        checks++;
        if ({bus.imem_we, count, done} !== {1'b0, 9'd3, 1'b1}) begin
            errors++; $display("FAIL finish_hold we=%b count=%0d done=%b want 0 3 1", bus.imem_we, count, done);
        end
        checks++;
        if (wr_cnt - w0 != 3) begin
            errors++; $display("FAIL finish_writes got=%0d want 3", wr_cnt - w0);
        end
    endtask

    task automatic test_start_wins;
        pulse_start();
        drive(3'b001, 3'd1, 3'd1, 3'd0, 2'd0, 8'h05);
        tick();
        start = 1'b1; finish = 1'b1;
        tick(); start = 1'b0; finish = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if ({count, bus.imem_we, busy, done, bus.imem_addr} !== {9'd0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL start_wins count=%0d we=%b busy=%b done=%b addr=%0d want 0 0 1 0 0", count, bus.imem_we, busy, done, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start();
        drive(3'b010, 3'd2, 3'd2, 3'd0, 2'd0, 8'h11);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.imem_we, busy, done, err, bus.imem_addr, bus.imem_wdata, count} !== 38'd0) begin
            errors++; $display("FAIL reset_mid ready=%b we=%b busy=%b done=%b err=%b addr=%0d wdata=%h count=%0d want all 0", bus.in_ready, bus.imem_we, busy, done, err, bus.imem_addr, bus.imem_wdata, count);
        end
        w0 = wr_cnt;
        tick(); tick();
        checks++;
        if (wr_cnt != w0) begin
            errors++; $display("FAIL reset_no_write writes=%0d want 0", wr_cnt - w0);
        end
        @(negedge clk); reset_n = 1'b1; bus.in_valid = 1'b0;
        tick();
        pulse_start();
        drive(3'b000, 3'd7, 3'd0, 3'd1, 2'b01, 8'h00);
        tick(); bus.in_valid = 1'b0;
        // {000,111,000,0,001,0,01} = 0x1C09
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, count} !== {1'b1, 8'd0, 16'h1C09, 9'd1}) begin
            errors++; $display("FAIL reset_restart we=%b addr=%0d wdata=%h count=%0d want 1 0 1c09 1", bus.imem_we, bus.imem_addr, bus.imem_wdata, count);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start();
        checks++;
        if (checksum !== 16'h0000) begin
            errors++; $display("FAIL cks_clear got=%h want 0000", checksum);
        end
        drive(3'b000, 3'd0, 3'd0, 3'd0, 2'b01, 8'h00);
        tick(); tick(); bus.in_valid = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0;
        tick();
        checks++;
        if ({done, checksum} !== {1'b1, 16'h0003}) begin
            errors++; $display("FAIL cks_done done=%b checksum=%h want 1 0003", done, checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_imm_err();
        test_max_words();
        test_finish();
        test_start_wins();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
